mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle MIPS data-memory bus, downstream of the core alongside data memory. Snoops `memwrite`/`dataadr`/`writedata` every cycle. Stores to the TX register are queued in a small FIFO and serialized 8N1, LSB first, on `txd`. A status word is readable at a second address.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit (≥2).
- `FIFO_DEPTH`, 4, byte FIFO entries (power of two, ≥2).
- `TX_ADDR`, 32'h0000_0080, store address that enqueues `writedata[7:0]`.
- `STAT_ADDR`, 32'h0000_0084, status register address.
- `clk`  input  1  rising-edge system clock, same as the core.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `memwrite`  input  1  core store strobe.
- `dataadr`  input  32  core data address (ALU result).
- `writedata`  input  32  core store data.
- `rdata`  output  32  status readback, combinational on `dataadr`.
- `txd`  output  1  serial line, idle high, registered.
- `busy`  output  1  high while a frame is on the line or FIFO non-empty.

## Operation
- Push: at a rising edge with `memwrite`=1 and `dataadr`==`TX_ADDR`. Byte = `writedata[7:0]`; upper bits ignored. Accepted if FIFO not full, or if a pop occurs on the same edge.
- Rejected push (full, no simultaneous pop): byte dropped; sticky `ovf` set.
- Store to `STAT_ADDR` with `writedata[2]`=1 clears `ovf`. Other bits of that store are ignored. Set and clear on the same edge: set wins.
- `rdata` = {29'b0, ovf, full, busy} when `dataadr`==`STAT_ADDR`, else 32'b0.
- Any other `dataadr` value: ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If FIFO non-empty: pop into shift register, load bit counter, go to START.
  - START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `txd`=shift[0], shifted right every `CLKS_PER_BIT` cycles, 8 bits, then go to STOP.
  - STOP: `txd`=1 for `CLKS_PER_BIT` cycles. On the final cycle: if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every state entry.
- Bit index: 3 bits, 0..7.
- FIFO pointers: log2(`FIFO_DEPTH`)+1 bits.
  - Full when the pointer MSBs differ and the low bits are equal.
  - Wrap-around is natural.

## Timing
- Reset values: `txd`=1, `busy`=0, `ovf`=0, FIFO empty, state IDLE, all counters 0.
- `rdata` has no registered state beyond `ovf`/`full`/`busy`.
- Reset asserted mid-frame: `txd` goes to 1 immediately (asynchronous), FIFO contents discarded, FSM returns to IDLE.
- Latency: store at edge N. FIFO count is 1 after N. Pop at N+1, and `txd` falls after edge N+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the stop bit is followed immediately by the next start bit.
- `busy` rises after edge N (registered from FIFO/FSM state). It falls after the edge that ends the last stop bit with the FIFO empty.
- `full`/`ovf` readback reflects state after the most recent edge.

## Structure
- Shared package `mmio_pkg`: `TX_ADDR`/`STAT_ADDR` default constants, status bit index constants (BUSY=0, FULL=1, OVF=2), FSM state enum `uart_state_t`.
- Sub-module `sync_fifo`: parameterized width/depth, push/pop/full/empty, same clock and async active-low reset.
- The top level holds address decode, `ovf` flag, FSM, baud counter and shift register.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.
- Reset, then hold `reset`=0 mid-run → `txd`=1, `busy`=0, and `rdata` at 0x84 = 0x0 immediately.
- Store 0x000000A5 to 0x80 → `txd` low 4 cycles starting the edge after the push, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. `busy` falls 40 cycles after `txd` fell.
- Store 0x1234_5641 to 0x80 → frame carries 0x41 only.
- Five stores in five consecutive cycles → first popped, four queued, none dropped, `ovf`=0. Five frames back-to-back; `txd` never idles between stop and start.
- Six consecutive stores → sixth dropped. `rdata` at 0x84 = 0x7 while full and sending. Store 0x4 to 0x84 → `ovf` cleared, `rdata` = 0x3.
- Assert reset during DATA of the second frame → `txd`=1 at once, FIFO empty. After release, a new store produces a clean frame.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus addresses,
// status-word bit positions and the serializer state encoding.
// Pure declarations; no logic, no latency, no flow control.
package mmio_pkg;

  localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_0080;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h0000_0084;

  // Bit positions inside the status word
  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Latency: a push is visible on o_pop_dat after the next edge.
// Backpressure: push is accepted while not full, or when full if a pop occurs on the same edge.
//
// Ports: i_clk, i_rst_n (async active-low), i_push/i_push_dat write side,
//        i_pop/o_pop_dat read side, o_full/o_empty status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when low bits match
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: snoops core stores, queues TX bytes, sends 8N1 LSB first.
// Latency: store at edge N, start bit on txd after edge N+1; frames are 10*CLKS_PER_BIT cycles.
// Backpressure: none toward the core; stores to a full FIFO are dropped and set sticky ovf.
//
// Ports: clk, reset (async active-low), memwrite/dataadr/writedata snooped store bus,
//        rdata status readback (comb on dataadr), txd serial out, busy activity flag.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR    = STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_t r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit_idx, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_txd, w_txd_nxt;
  logic          r_ovf;

  logic          w_push_req, w_push, w_pop, w_full, w_empty, w_busy;
  logic          w_ovf_set, w_ovf_clr, w_baud_last;
  logic [7:0]    w_fifo_dat;
  logic [31:0]   w_stat;
  logic          w_unused;

  // Upper store bits carry nothing for this block
  assign w_unused = ^writedata[31:8];

  assign w_push_req = memwrite && (dataadr == TX_ADDR);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = memwrite && (dataadr == STAT_ADDR) && writedata[STAT_OVF];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_push     (w_push),
    .i_push_dat (writedata[7:0]),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BW'(1);
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dat;
          w_bit_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit when more data is queued
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dat;
            w_bit_nxt   = '0;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
      end
    endcase

    // txd is registered, so derive it from where the FSM will be after the edge
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
      // Overflow set takes priority over a clear on the same edge
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Built only from registered FSM and FIFO pointer state
  assign w_busy = (r_state != IDLE) || !w_empty;

  always_comb begin
    w_stat            = '0;
    w_stat[STAT_BUSY] = w_busy;
    w_stat[STAT_FULL] = w_full;
    w_stat[STAT_OVF]  = r_ovf;
  end

  assign rdata = (dataadr == STAT_ADDR) ? w_stat : 32'b0;
  assign txd   = r_txd;
  assign busy  = w_busy;

endmodule
